// File: rtl/mac_pkg.sv
// Shared definitions for the mac datapath and its sequencer: instruction
// encodings, sequencer states and the lane arithmetic helpers.
package mac_pkg;

    // mac instruction encodings; bit 2 selects dual 8x8 lanes
    localparam logic [2:0] MAC_CLR  = 3'b000;
    localparam logic [2:0] MAC_MUL  = 3'b001;
    localparam logic [2:0] MAC_ACC  = 3'b010;
    localparam logic [2:0] MAC_SAT  = 3'b011;
    localparam logic [2:0] MAC_DMUL = 3'b101;
    localparam logic [2:0] MAC_DACC = 3'b110;
    localparam logic [2:0] MAC_DSAT = 3'b111;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FIRST = 3'd1,
        ACCUM = 3'd2,
        SAT   = 3'd3,
        DRAIN = 3'd4
    } state_t;

    // Map a 16x16 opcode onto its dual-lane twin when dual is set.
    function automatic logic [2:0] mac_op(input logic dual, input logic [2:0] base);
        return base | {dual, 2'b00};
    endfunction

    // Clamp a 40-bit accumulator to the signed 32-bit range.
    function automatic logic [39:0] sat40(input logic [39:0] x);
        if (x[39:31] == {9{x[31]}})
            return x;
        return x[39] ? 40'hFF_8000_0000 : 40'h00_7FFF_FFFF;
    endfunction

    // Clamp a 20-bit lane accumulator to the signed 16-bit range.
    function automatic logic [19:0] sat20(input logic [19:0] x);
        if (x[19:15] == {5{x[15]}})
            return x;
        return x[19] ? 20'hF_8000 : 20'h0_7FFF;
    endfunction

    // Lane guard bits live in protect, lane values in result halves.
    function automatic logic [39:0] dual_pack(input logic [19:0] h, input logic [19:0] l);
        return {h[19:16], l[19:16], h[15:0], l[15:0]};
    endfunction

endpackage

// File: rtl/mac.sv
// 16x16 signed multiply-accumulate datapath with 8 guard bits, or two
// independent 8x8 lanes with 4 guard bits each. One register stage:
// an instruction is absorbed on the first edge after it is presented.
module mac
    import mac_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall,
    input  logic [2:0]  instruction,
    input  logic [15:0] multiplier,
    input  logic [15:0] multiplicand,
    output logic [31:0] result,
    output logic [7:0]  protect
);

    logic        [39:0] r_acc;
    logic        [39:0] w_nxt;
    logic signed [31:0] w_a16, w_b16, w_p16;
    logic signed [39:0] w_acc40, w_p40;
    logic signed [15:0] w_ah, w_bh, w_al, w_bl, w_ph, w_pl;
    logic signed [19:0] w_acc_h, w_acc_l, w_ph20, w_pl20;

    assign w_a16   = {{16{multiplier[15]}}, multiplier};
    assign w_b16   = {{16{multiplicand[15]}}, multiplicand};
    assign w_p16   = w_a16 * w_b16;
    assign w_p40   = {{8{w_p16[31]}}, w_p16};
    assign w_acc40 = r_acc;

    assign w_ah    = {{8{multiplier[15]}}, multiplier[15:8]};
    assign w_bh    = {{8{multiplicand[15]}}, multiplicand[15:8]};
    assign w_al    = {{8{multiplier[7]}}, multiplier[7:0]};
    assign w_bl    = {{8{multiplicand[7]}}, multiplicand[7:0]};
    assign w_ph    = w_ah * w_bh;
    assign w_pl    = w_al * w_bl;
    assign w_ph20  = {{4{w_ph[15]}}, w_ph};
    assign w_pl20  = {{4{w_pl[15]}}, w_pl};
    assign w_acc_h = {r_acc[39:36], r_acc[31:16]};
    assign w_acc_l = {r_acc[35:32], r_acc[15:0]};

    // Next accumulator value for the presented instruction
    always_comb begin
        w_nxt = r_acc;
        case (instruction)
            MAC_MUL:  w_nxt = w_p40;
            MAC_ACC:  w_nxt = w_acc40 + w_p40;
            MAC_SAT:  w_nxt = sat40(r_acc);
            MAC_DMUL: w_nxt = dual_pack(w_ph20, w_pl20);
            MAC_DACC: w_nxt = dual_pack(w_acc_h + w_ph20, w_acc_l + w_pl20);
            MAC_DSAT: w_nxt = dual_pack(sat20(w_acc_h), sat20(w_acc_l));
            default:  w_nxt = '0;
        endcase
    end

    // Accumulator register; stall freezes it
    always_ff @(posedge clk) begin
        if (!reset_n)
            r_acc <= '0;
        else if (!stall)
            r_acc <= w_nxt;
    end

    assign result  = r_acc[31:0];
    assign protect = r_acc[39:32];

endmodule

// File: rtl/mac_seq.sv
// Dot-product sequencer for one mac instance: takes a command, streams the
// operand pairs into mac, optionally saturates, then captures
// {protect,result} into a single result buffer behind a valid/ready port.
// All mac-facing outputs are registered so they hold for a whole cycle.
module mac_seq
    import mac_pkg::*;
#(
    parameter int LEN_W   = 8,
    parameter int MAC_LAT = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             cmd_dual,
    input  logic             cmd_sat,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [15:0]      op_a,
    input  logic [15:0]      op_b,
    output logic [2:0]       mac_instruction,
    output logic [15:0]      mac_multiplier,
    output logic [15:0]      mac_multiplicand,
    input  logic [31:0]      mac_result,
    input  logic [7:0]       mac_protect,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_data,
    output logic [7:0]       res_protect,
    output logic             busy
);

    // The last instruction is issued on the edge entering DRAIN; mac shows
    // its effect MAC_LAT edges later, so DRAIN spans MAC_LAT cycles.
    localparam int CNT_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

    state_t             r_state;
    logic [LEN_W-1:0]   r_remaining;
    logic [CNT_W-1:0]   r_drain_cnt;
    logic               r_dual, r_sat, r_zero_len;
    logic [2:0]         r_instr;
    logic [15:0]        r_mplier, r_mcand;
    logic               r_res_valid;
    logic [31:0]        r_res_data;
    logic [7:0]         r_res_protect;

    logic               w_cmd_fire, w_op_fire, w_last, w_drain_done;
    state_t             w_post;

    assign cmd_ready    = !reset && (r_state == IDLE) && !r_res_valid;
    assign op_ready     = !reset && ((r_state == FIRST) || (r_state == ACCUM));
    assign w_cmd_fire   = cmd_valid && cmd_ready;
    assign w_op_fire    = op_valid && op_ready;
    assign w_last       = (r_remaining == LEN_W'(1));
    assign w_post       = r_sat ? SAT : DRAIN;
    assign w_drain_done = (r_drain_cnt == CNT_W'(MAC_LAT - 1));

    // Command FSM, mac instruction issue and result capture
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_remaining   <= '0;
            r_drain_cnt   <= '0;
            r_dual        <= 1'b0;
            r_sat         <= 1'b0;
            r_zero_len    <= 1'b0;
            r_instr       <= MAC_CLR;
            r_mplier      <= '0;
            r_mcand       <= '0;
            r_res_valid   <= 1'b0;
            r_res_data    <= '0;
            r_res_protect <= '0;
        end else begin
            if (r_res_valid && res_ready)
                r_res_valid <= 1'b0;

            case (r_state)
                IDLE: begin
                    r_instr  <= MAC_CLR;
                    r_mplier <= '0;
                    r_mcand  <= '0;
                    if (w_cmd_fire) begin
                        r_dual      <= cmd_dual;
                        r_sat       <= cmd_sat;
                        r_remaining <= cmd_len;
                        r_drain_cnt <= '0;
                        r_zero_len  <= (cmd_len == '0);
                        r_state     <= (cmd_len == '0) ? DRAIN : FIRST;
                    end
                end

                FIRST: begin
                    if (w_op_fire) begin
                        r_instr     <= mac_op(r_dual, MAC_MUL);
                        r_mplier    <= op_a;
                        r_mcand     <= op_b;
                        r_remaining <= r_remaining - LEN_W'(1);
                        r_drain_cnt <= '0;
                        r_state     <= w_last ? w_post : ACCUM;
                    end else begin
                        // keep mac cleared until the first pair shows up
                        r_instr  <= MAC_CLR;
                        r_mplier <= '0;
                        r_mcand  <= '0;
                    end
                end

                ACCUM: begin
                    // a bubble still issues ACC, but with zero operands
                    r_instr <= mac_op(r_dual, MAC_ACC);
                    if (w_op_fire) begin
                        r_mplier    <= op_a;
                        r_mcand     <= op_b;
                        r_remaining <= r_remaining - LEN_W'(1);
                        r_drain_cnt <= '0;
                        if (w_last)
                            r_state <= w_post;
                    end else begin
                        r_mplier <= '0;
                        r_mcand  <= '0;
                    end
                end

                SAT: begin
                    r_instr     <= mac_op(r_dual, MAC_SAT);
                    r_mplier    <= '0;
                    r_mcand     <= '0;
                    r_drain_cnt <= '0;
                    r_state     <= DRAIN;
                end

                DRAIN: begin
                    // hold the accumulator while the pipeline empties
                    r_instr  <= r_zero_len ? MAC_CLR : mac_op(r_dual, MAC_ACC);
                    r_mplier <= '0;
                    r_mcand  <= '0;
                    if (w_drain_done) begin
                        r_res_data    <= mac_result;
                        r_res_protect <= mac_protect;
                        r_res_valid   <= 1'b1;
                        r_state       <= IDLE;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + CNT_W'(1);
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

    assign mac_instruction  = r_instr;
    assign mac_multiplier   = r_mplier;
    assign mac_multiplicand = r_mcand;
    assign res_valid        = r_res_valid;
    assign res_data         = r_res_data;
    assign res_protect      = r_res_protect;
    assign busy             = (r_state != IDLE);

endmodule

// File: tb/tb_mac_seq.sv
// Directed bench for mac_seq driving a mac datapath instance.
module tb_mac_seq;
    import mac_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready, cmd_dual, cmd_sat;
    logic [7:0]  cmd_len;
    logic        op_valid, op_ready;
    logic [15:0] op_a, op_b;
    logic [2:0]  mac_instruction;
    logic [15:0] mac_multiplier, mac_multiplicand;
    logic [31:0] mac_result;
    logic [7:0]  mac_protect;
    logic        res_valid, res_ready;
    logic [31:0] res_data;
    logic [7:0]  res_protect;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] va [8];
    logic [15:0] vb [8];
    int          gap [8];
    int          lat;
    bit          tmo;

    always #5 clk = ~clk;

    mac_seq #(.LEN_W(8), .MAC_LAT(2)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
        .cmd_dual(cmd_dual), .cmd_sat(cmd_sat),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .mac_instruction(mac_instruction), .mac_multiplier(mac_multiplier),
        .mac_multiplicand(mac_multiplicand), .mac_result(mac_result),
        .mac_protect(mac_protect),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_protect(res_protect), .busy(busy)
    );

    mac u_mac (
        .clk(clk), .reset_n(~reset), .stall(1'b0),
        .instruction(mac_instruction), .multiplier(mac_multiplier),
        .multiplicand(mac_multiplicand), .result(mac_result), .protect(mac_protect)
    );

    // Issue one command and stream va/vb with gap[i] idle cycles after pair i.
    // lat counts edges from the command accept edge to res_valid.
    task automatic run_cmd(input int len, input logic dual, input logic sat,
                           output int l, output bit t);
        int w = 0;
        int idx = 0;
        int g = 0;
        bit hs;
        l = 0;
        t = 1'b0;
        cmd_valid = 1'b1; cmd_len = 8'(len); cmd_dual = dual; cmd_sat = sat;
        while (!cmd_ready && w < 20) begin
            @(posedge clk); #1; w++;
        end
        if (!cmd_ready) begin
            cmd_valid = 1'b0; t = 1'b1; return;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        while (l < 200) begin
            if (idx < len && g == 0) begin
                op_valid = 1'b1; op_a = va[idx]; op_b = vb[idx];
            end else begin
                op_valid = 1'b0; op_a = '0; op_b = '0;
                if (g > 0) g--;
            end
            hs = op_valid && op_ready;
            @(posedge clk); #1; l++;
            if (hs) begin
                g = gap[idx];
                idx++;
            end
            if (res_valid) break;
        end
        op_valid = 1'b0;
        if (!res_valid) t = 1'b1;
    endtask

    // Consume the buffered result with a one-cycle res_ready pulse.
    task automatic take_result();
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cmd_valid = 0; cmd_len = 0; cmd_dual = 0; cmd_sat = 0;
        op_valid = 0; op_a = 0; op_b = 0; res_ready = 0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL rst_cmd_ready got %b want 0", cmd_ready); end
        n_checks++; if (op_ready !== 1'b0) begin n_fail++; $display("FAIL rst_op_ready got %b want 0", op_ready); end
        n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL rst_res_valid got %b want 0", res_valid); end
        n_checks++; if (res_data !== 32'h0) begin n_fail++; $display("FAIL rst_res_data got %h want 0", res_data); end
        n_checks++; if (res_protect !== 8'h0) begin n_fail++; $display("FAIL rst_res_protect got %h want 0", res_protect); end
        n_checks++; if (mac_instruction !== MAC_CLR) begin n_fail++; $display("FAIL rst_instr got %b want 000", mac_instruction); end
        n_checks++; if (mac_multiplier !== 16'h0 || mac_multiplicand !== 16'h0) begin n_fail++; $display("FAIL rst_operands got %h/%h want 0/0", mac_multiplier, mac_multiplicand); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", busy); end
        reset = 1'b0;
        #1;
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_cmd_ready got %b want 1", cmd_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        // 2*3 + (-4)*5 + 7*(-1) = 6 - 20 - 7 = -21
        va[0] = 16'd2;  vb[0] = 16'd3;
        va[1] = -16'sd4; vb[1] = 16'd5;
        va[2] = 16'd7;  vb[2] = -16'sd1;
        gap = '{default: 0};
        run_cmd(3, 1'b0, 1'b0, lat, tmo);
        n_checks++; if (tmo) begin n_fail++; $display("FAIL basic_timeout got no result want res_valid"); end
        n_checks++; if (res_data !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL basic_data got %h want ffffffeb", res_data); end
        n_checks++; if (res_protect !== 8'hFF) begin n_fail++; $display("FAIL basic_protect got %h want ff", res_protect); end
        n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL basic_latency got %0d want 5", lat); end
        take_result();
        n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL basic_res_clear got %b want 0", res_valid); end
    endtask

    task automatic test_large_sat();
        // 3 * 32767^2 = 3 * 0x3FFF0001 = 0xBFFD0003, over the 32-bit signed range
        for (int i = 0; i < 3; i++) begin va[i] = 16'h7FFF; vb[i] = 16'h7FFF; end
        gap = '{default: 0};
        run_cmd(3, 1'b0, 1'b0, lat, tmo);
        n_checks++; if (tmo) begin n_fail++; $display("FAIL big_timeout got no result want res_valid"); end
        n_checks++; if (res_data !== 32'hBFFD_0003) begin n_fail++; $display("FAIL big_data got %h want bffd0003", res_data); end
        n_checks++; if (res_protect !== 8'h00) begin n_fail++; $display("FAIL big_protect got %h want 00", res_protect); end
        n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL big_latency got %0d want 5", lat); end
        take_result();
        run_cmd(3, 1'b0, 1'b1, lat, tmo);
        n_checks++; if (tmo) begin n_fail++; $display("FAIL sat_timeout got no result want res_valid"); end
        n_checks++; if (res_data !== 32'h7FFF_FFFF) begin n_fail++; $display("FAIL sat_data got %h want 7fffffff", res_data); end
        n_checks++; if (res_protect !== 8'h00) begin n_fail++; $display("FAIL sat_protect got %h want 00", res_protect); end
        n_checks++; if (lat !== 6) begin n_fail++; $display("FAIL sat_latency got %0d want 6", lat); end
        take_result();
    endtask

    task automatic test_dual();
        // hi lane 2*4 = 8, lo lane 3*5 = 15
        va[0] = 16'h0203; vb[0] = 16'h0405;
        gap = '{default: 0};
        run_cmd(1, 1'b1, 1'b0, lat, tmo);
        n_checks++; if (tmo) begin n_fail++; $display("FAIL dual_timeout got no result want res_valid"); end
        n_checks++; if (res_data !== 32'h0008_000F) begin n_fail++; $display("FAIL dual_data got %h want 0008000f", res_data); end
        n_checks++; if (res_protect !== 8'h00) begin n_fail++; $display("FAIL dual_protect got %h want 00", res_protect); end
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL dual_latency got %0d want 3", lat); end
        take_result();
    endtask

    task automatic test_bubbles();
        // 1*2 + 3*4 + (-5)*6 + 100*(-7) = 2 + 12 - 30 - 700 = -716 = 0xFFFFFD34
        va[0] = 16'd1;   vb[0] = 16'd2;
        va[1] = 16'd3;   vb[1] = 16'd4;
        va[2] = -16'sd5; vb[2] = 16'd6;
        va[3] = 16'd100; vb[3] = -16'sd7;
        gap = '{default: 0};
        run_cmd(4, 1'b0, 1'b0, lat, tmo);
        n_checks++; if (res_data !== 32'hFFFF_FD34 || tmo) begin n_fail++; $display("FAIL nobub_data got %h want fffffd34", res_data); end
        n_checks++; if (lat !== 6) begin n_fail++; $display("FAIL nobub_latency got %0d want 6", lat); end
        take_result();
        gap[0] = 1; gap[1] = 1; gap[2] = 1;
        run_cmd(4, 1'b0, 1'b0, lat, tmo);
        n_checks++; if (res_data !== 32'hFFFF_FD34 || tmo) begin n_fail++; $display("FAIL bub_data got %h want fffffd34", res_data); end
        n_checks++; if (res_protect !== 8'hFF) begin n_fail++; $display("FAIL bub_protect got %h want ff", res_protect); end
        n_checks++; if (lat !== 9) begin n_fail++; $display("FAIL bub_latency got %0d want 9", lat); end
        take_result();
        gap = '{default: 0};
    endtask

    task automatic test_back_to_back();
        // 100 * 200 = 20000 = 0x4E20, left unconsumed for 5 cycles
        va[0] = 16'd100; vb[0] = 16'd200;
        gap = '{default: 0};
        run_cmd(1, 1'b0, 1'b0, lat, tmo);
        n_checks++; if (lat !== 3 || tmo) begin n_fail++; $display("FAIL hold_latency got %0d want 3", lat); end
        cmd_valid = 1'b1; cmd_len = 8'd0; cmd_dual = 1'b0; cmd_sat = 1'b0;
        op_valid = 1'b1; op_a = 16'h1234; op_b = 16'h1234;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_checks++; if (res_valid !== 1'b1 || res_data !== 32'h0000_4E20) begin n_fail++; $display("FAIL hold_data cycle %0d got v=%b %h want v=1 00004e20", i, res_valid, res_data); end
            n_checks++; if (cmd_ready !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL hold_cmd cycle %0d got ready=%b busy=%b want 0/0", i, cmd_ready, busy); end
            n_checks++; if (op_ready !== 1'b0) begin n_fail++; $display("FAIL hold_op_ready cycle %0d got %b want 0", i, op_ready); end
        end
        op_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        n_checks++; if (res_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL overlap got valid=%b busy=%b want 0/0", res_valid, busy); end
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL overlap_cmd_ready got %b want 1", cmd_ready); end
        run_cmd(0, 1'b0, 1'b0, lat, tmo);
        n_checks++; if (tmo || res_data !== 32'h0 || res_protect !== 8'h0) begin n_fail++; $display("FAIL len0_data got %h/%h want 0/0", res_protect, res_data); end
        n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL len0_latency got %0d want 2", lat); end
        take_result();
    endtask

    task automatic test_mid_reset();
        cmd_valid = 1'b1; cmd_len = 8'd4; cmd_dual = 1'b0; cmd_sat = 1'b0;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        op_valid = 1'b1; op_a = 16'd1; op_b = 16'd1;
        @(posedge clk); #1;
        n_checks++; if (mac_instruction !== MAC_MUL || mac_multiplier !== 16'd1) begin n_fail++; $display("FAIL first_issue got %b/%h want 001/0001", mac_instruction, mac_multiplier); end
        @(posedge clk); #1;
        n_checks++; if (mac_instruction !== MAC_ACC || busy !== 1'b1) begin n_fail++; $display("FAIL accum_issue got %b busy=%b want 010 busy=1", mac_instruction, busy); end
        op_valid = 1'b0;
        reset = 1'b1;
        #1;
        n_checks++; if (cmd_ready !== 1'b0 || op_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_ready got cmd=%b op=%b want 0/0", cmd_ready, op_ready); end
        @(posedge clk); #1;
        reset = 1'b0;
        n_checks++; if (busy !== 1'b0 || res_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_state got busy=%b valid=%b want 0/0", busy, res_valid); end
        n_checks++; if (mac_instruction !== MAC_CLR) begin n_fail++; $display("FAIL midrst_instr got %b want 000", mac_instruction); end
        @(posedge clk); #1;
        n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_no_result got %b want 0", res_valid); end
        va[0] = 16'd2;  vb[0] = 16'd3;
        va[1] = -16'sd4; vb[1] = 16'd5;
        va[2] = 16'd7;  vb[2] = -16'sd1;
        gap = '{default: 0};
        run_cmd(3, 1'b0, 1'b0, lat, tmo);
        n_checks++; if (tmo || res_data !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL after_rst_data got %h want ffffffeb", res_data); end
        n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL after_rst_latency got %0d want 5", lat); end
        take_result();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_large_sat();
        test_dual();
        test_bubbles();
        test_back_to_back();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no finish want finish before 200000");
        $fatal(1);
    end

endmodule
